// File: rtl/pll_pfd_lock.sv
// Phase/frequency detector with lock detector for the PLL loop.
// Optional cycle-slip detection is enabled by defining PFD_SLIP_DET_EN.
module pll_pfd_lock #(
   parameter int CNT_W    = 4,
   parameter int LOCK_WIN = 2,
   parameter int LOCK_CNT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ref_in,
   input  logic             fb_in,
   output logic             up,
   output logic             dn,
   output logic [CNT_W-1:0] phase_err,
   output logic             err_lead,
   output logic             err_valid,
   output logic             locked
`ifdef PFD_SLIP_DET_EN
   ,
   output logic             cycle_slip
`endif
);

   typedef enum logic [1:0] {IDLE, UP, DN} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] WIN      = CNT_W'(LOCK_WIN);
   localparam logic [7:0]       LOCK_TGT = 8'(LOCK_CNT);

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   function automatic logic [7:0] sat_lock(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   logic ref_p0, ref_p1, ref_p2, ref_e;
   logic fb_p0, fb_p1, fb_p2, fb_e;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, pe_nxt;
   logic             ev_nxt, lead_nxt;
   logic [7:0]       lock_cnt;
`ifdef PFD_SLIP_DET_EN
   logic             slip_nxt;
`endif

   // Stage p0/p1: two-flop synchronizer; p2: delay flop; edge pulse registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_p0 <= 1'b0;
         ref_p1 <= 1'b0;
         ref_p2 <= 1'b0;
         ref_e  <= 1'b0;
         fb_p0  <= 1'b0;
         fb_p1  <= 1'b0;
         fb_p2  <= 1'b0;
         fb_e   <= 1'b0;
      end else begin
         ref_p0 <= ref_in;
         ref_p1 <= ref_p0;
         ref_p2 <= ref_p1;
         ref_e  <= ref_p1 & ~ref_p2;
         fb_p0  <= fb_in;
         fb_p1  <= fb_p0;
         fb_p2  <= fb_p1;
         fb_e   <= fb_p1 & ~fb_p2;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ev_nxt    = 1'b0;
      pe_nxt    = phase_err;
      lead_nxt  = err_lead;
`ifdef PFD_SLIP_DET_EN
      slip_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (ref_e && fb_e) begin
               ev_nxt   = 1'b1;
               pe_nxt   = '0;
               lead_nxt = 1'b0;
            end else if (ref_e) begin
               state_nxt = UP;
               cnt_nxt   = CNT_ONE;
            end else if (fb_e) begin
               state_nxt = DN;
               cnt_nxt   = CNT_ONE;
            end
         end
         UP: begin
            if (fb_e) begin
               ev_nxt   = 1'b1;
               pe_nxt   = cnt;
               lead_nxt = 1'b1;
               // A coincident opening edge starts the next comparison at once.
               if (ref_e) cnt_nxt = CNT_ONE;
               else       state_nxt = IDLE;
            end else begin
               cnt_nxt = sat_cnt(cnt);
`ifdef PFD_SLIP_DET_EN
               slip_nxt = ref_e;
`endif
            end
         end
         DN: begin
            if (ref_e) begin
               ev_nxt   = 1'b1;
               pe_nxt   = cnt;
               lead_nxt = 1'b0;
               if (fb_e) cnt_nxt = CNT_ONE;
               else      state_nxt = IDLE;
            end else begin
               cnt_nxt = sat_cnt(cnt);
`ifdef PFD_SLIP_DET_EN
               slip_nxt = fb_e;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Detector state and comparison result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         up        <= 1'b0;
         dn        <= 1'b0;
         err_valid <= 1'b0;
         phase_err <= '0;
         err_lead  <= 1'b0;
`ifdef PFD_SLIP_DET_EN
         cycle_slip <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         up        <= (state_nxt == UP);
         dn        <= (state_nxt == DN);
         err_valid <= ev_nxt;
         phase_err <= pe_nxt;
         err_lead  <= lead_nxt;
`ifdef PFD_SLIP_DET_EN
         cycle_slip <= slip_nxt;
`endif
      end
   end

   // Lock detector: consumes each strobe (or slip) on the following edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt <= 8'd0;
         locked   <= 1'b0;
`ifdef PFD_SLIP_DET_EN
      end else if (cycle_slip) begin
         lock_cnt <= 8'd0;
         locked   <= 1'b0;
`endif
      end else if (err_valid) begin
         if (phase_err <= WIN) begin
            lock_cnt <= sat_lock(lock_cnt);
            if (sat_lock(lock_cnt) >= LOCK_TGT) locked <= 1'b1;
         end else begin
            lock_cnt <= 8'd0;
            locked   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/pll_pfd_lock.md
Name: pll_pfd_lock

Overview:
- Digital phase/frequency detector with lock detector for the nano-scale PLL loop.
- Consumes the reference clock and the divided feedback pulse produced by the VCO scaler.
- Produces UP/DN correction pulses toward the loop filter/charge-pump model, a measured phase error per comparison, and a locked flag.
- All logic runs in the single system clock domain; ref_in and fb_in are sampled as asynchronous levels.

Parameters:
- CNT_W, 4: width of the phase-error counter; its saturation value is 2^CNT_W-1.
- LOCK_WIN, 2: largest phase error, in clk cycles, that counts as aligned.
- LOCK_CNT, 8: number of consecutive aligned comparisons required to assert locked (range 1..255).

Ports:
- clk, input, 1: system clock; every flop updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- ref_in, input, 1: reference clock level, asynchronous.
- fb_in, input, 1: divided feedback from the scaler, asynchronous.
- up, output, 1: high while the reference leads (state UP).
- dn, output, 1: high while the feedback leads (state DN).
- phase_err, output, CNT_W: magnitude of the last completed comparison, in clk cycles.
- err_lead, output, 1: 1 when the last comparison was ref-leading, 0 when fb-leading or aligned.
- err_valid, output, 1: one-cycle strobe; phase_err and err_lead are updated in the same cycle.
- locked, output, 1: loop-lock indication.

Behaviour:
- Reset and clock: clk is the single clock; rst is synchronous, active-high. When rst=1 at a clk edge:
  - state <= IDLE.
  - up, dn, err_valid, err_lead, locked <= 0; phase_err <= 0.
  - Counters and synchronizer/edge registers <= 0.
  - A reset asserted mid-measurement discards that measurement; no err_valid strobe is produced for it.
- Input sampling: each input passes through a 2-flop synchronizer, then a delay flop. A rising edge (ref_e / fb_e) is the synchronized value 1 with the delayed value 0. From an input rising to the edge pulse takes 3 clk edges.
- Outputs: up = (state==UP) and dn = (state==DN), both registered from state. up and dn are never 1 together.
- State machine, IDLE:
  - ref_e only: go to UP, cnt <= 1.
  - fb_e only: go to DN, cnt <= 1.
  - Both edges in the same cycle: stay IDLE, phase_err <= 0, err_lead <= 0, err_valid <= 1.
- State machine, UP:
  - Each cycle with no fb_e: cnt <= min(cnt+1, 2^CNT_W-1); cnt saturates and never wraps.
  - fb_e: phase_err <= cnt, err_lead <= 1, err_valid <= 1.
    - With ref_e in the same cycle: stay in UP and set cnt <= 1 (close the old comparison, open a new one).
    - Otherwise: go to IDLE.
  - ref_e without fb_e: stay in UP and keep counting (frequency-detector behaviour).
- State machine, DN: mirror of UP with ref_e and fb_e swapped and err_lead <= 0.
- Lock detect, evaluated on every err_valid, using the value being written:
  - phase_err <= LOCK_WIN: lock_cnt <= saturating lock_cnt+1. When lock_cnt reaches LOCK_CNT, locked <= 1, registered one cycle after the qualifying strobe.
  - phase_err > LOCK_WIN: lock_cnt <= 0 and locked <= 0 in the cycle after the strobe.
  - A saturated count always exceeds LOCK_WIN, so it always clears lock.
- Latency:
  - Closing edge at input to err_valid: 4 clk edges.
  - Qualifying err_valid to locked: 1 clk edge.

Optional Feature:
- Macro: PFD_SLIP_DET_EN.
- When defined:
  - Adds output port cycle_slip (1 bit, reset 0).
  - In UP, a ref_e without fb_e pulses cycle_slip for one cycle. In DN, an fb_e without ref_e does the same.
  - Each slip clears lock_cnt and locked on the next edge.
  - State and cnt behave exactly as without the feature.
- When undefined:
  - No cycle_slip port.
  - Extra leading edges are ignored by the lock detector.

Test Plan:
- Reset: rst=1 for 3 cycles with toggling inputs -> up=dn=err_valid=locked=0, phase_err=0 throughout; still 0 on the cycle after rst falls.
- Ref leads: ref rises, fb rises 5 clk later -> up high for 5 cycles, err_valid strobe with phase_err=5, err_lead=1, then IDLE with up=0.
- Fb leads with saturation (CNT_W=4): fb rises, ref rises 20 clk later -> dn high, phase_err=15, err_lead=0, locked cleared.
- Simultaneous edges: ref and fb rise on the same clk -> one err_valid with phase_err=0, up and dn stay 0. Eight such periods (LOCK_CNT=8) -> locked=1 one cycle after the 8th strobe.
- Loss of lock: after lock, one comparison with error 3 (LOCK_WIN=2) -> locked=0 the cycle after the strobe; needs 8 fresh aligned comparisons to relock.
- Slip and reset mid-measurement: two ref edges before any fb edge -> up held, cycle_slip pulses once (with PFD_SLIP_DET_EN); rst asserted while up=1 -> up=0 next edge, no err_valid.
